// File: rtl/net_frame_sequencer.sv
// Frame sequencer for the digit network: forwards one frame of pixels, waits for
// the classification or a timeout, and presents the result on a valid/ready port.
module net_frame_sequencer #(
  parameter int unsigned dataWidth     = 16,
  parameter int unsigned pixels        = 784,
  parameter int unsigned outWidth      = 4,
  parameter int unsigned timeoutCycles = 4095,
  parameter int unsigned cntWidth      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  input  logic [dataWidth-1:0] s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic                 net_valid,
  output logic [dataWidth-1:0] net_data,
  input  logic                 net_out_valid,
  input  logic [outWidth-1:0]  net_out_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [outWidth-1:0]  res_digit,
  output logic                 res_err,
  output logic                 busy,
  output logic [cntWidth-1:0]  frame_count
);

  localparam int unsigned PixW = (pixels > 1) ? $clog2(pixels + 1) : 1;
  localparam int unsigned ToW  = (timeoutCycles > 1) ? $clog2(timeoutCycles + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_WAIT   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [PixW-1:0]       r_pix_cnt, w_pix_cnt_nxt;
  logic [ToW-1:0]        r_to_cnt, w_to_cnt_nxt;
  logic                  r_frm_err, w_frm_err_nxt;
  logic                  r_net_valid, w_net_valid_nxt;
  logic [dataWidth-1:0]  r_net_data, w_net_data_nxt;
  logic                  r_res_valid, w_res_valid_nxt;
  logic [outWidth-1:0]   r_res_digit, w_res_digit_nxt;
  logic                  r_res_err, w_res_err_nxt;
  logic                  r_busy, w_busy_nxt;
  logic [cntWidth-1:0]   r_frame_count, w_frame_count_nxt;

  logic                  w_accept;
  logic [PixW-1:0]       w_pix_idx;
  logic                  w_is_last;
  logic                  w_timeout;

  // Ready is forced low while reset is asserted so no word is taken during reset.
  assign s_ready   = rst_n & ((r_state == S_IDLE) | (r_state == S_STREAM));
  assign w_accept  = s_valid & s_ready;
  assign w_pix_idx = (r_state == S_IDLE) ? '0 : r_pix_cnt;
  assign w_is_last = (w_pix_idx == PixW'(pixels - 1));
  assign w_timeout = (r_to_cnt == ToW'(timeoutCycles - 1));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pix_cnt     <= '0;
      r_to_cnt      <= '0;
      r_frm_err     <= 1'b0;
      r_net_valid   <= 1'b0;
      r_net_data    <= '0;
      r_res_valid   <= 1'b0;
      r_res_digit   <= '0;
      r_res_err     <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pix_cnt     <= w_pix_cnt_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      r_frm_err     <= w_frm_err_nxt;
      r_net_valid   <= w_net_valid_nxt;
      r_net_data    <= w_net_data_nxt;
      r_res_valid   <= w_res_valid_nxt;
      r_res_digit   <= w_res_digit_nxt;
      r_res_err     <= w_res_err_nxt;
      r_busy        <= w_busy_nxt;
      r_frame_count <= w_frame_count_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_pix_cnt_nxt     = r_pix_cnt;
    w_to_cnt_nxt      = r_to_cnt;
    w_frm_err_nxt     = r_frm_err;
    w_net_valid_nxt   = 1'b0;
    w_net_data_nxt    = r_net_data;
    w_res_valid_nxt   = r_res_valid;
    w_res_digit_nxt   = r_res_digit;
    w_res_err_nxt     = r_res_err;
    w_frame_count_nxt = r_frame_count;

    // s_last only flags framing errors; frame length is fixed.
    if (w_accept) begin
      w_net_valid_nxt = 1'b1;
      w_net_data_nxt  = s_data;
      if (s_last != w_is_last) begin
        w_frm_err_nxt = 1'b1;
      end
    end

    case (r_state)
      S_IDLE, S_STREAM: begin
        if (w_accept) begin
          if (w_is_last) begin
            w_state_nxt   = S_WAIT;
            w_pix_cnt_nxt = '0;
            w_to_cnt_nxt  = '0;
          end else begin
            w_state_nxt   = S_STREAM;
            w_pix_cnt_nxt = w_pix_idx + PixW'(1);
          end
        end
      end
      S_WAIT: begin
        w_to_cnt_nxt = r_to_cnt + ToW'(1);
        // A result arriving on the timeout cycle takes priority.
        if (net_out_valid) begin
          w_state_nxt     = S_HOLD;
          w_res_valid_nxt = 1'b1;
          w_res_digit_nxt = net_out_data;
          w_res_err_nxt   = r_frm_err;
        end else if (w_timeout) begin
          w_state_nxt     = S_HOLD;
          w_res_valid_nxt = 1'b1;
          w_res_digit_nxt = '1;
          w_res_err_nxt   = 1'b1;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          w_state_nxt       = S_IDLE;
          w_res_valid_nxt   = 1'b0;
          w_res_err_nxt     = 1'b0;
          w_frm_err_nxt     = 1'b0;
          w_frame_count_nxt = r_frame_count + cntWidth'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign net_valid   = r_net_valid;
  assign net_data    = r_net_data;
  assign res_valid   = r_res_valid;
  assign res_digit   = r_res_digit;
  assign res_err     = r_res_err;
  assign busy        = r_busy;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_net_frame_sequencer.sv
// Scoreboard bench for net_frame_sequencer: a driver feeds frames and results while
// a monitor compares forwarded pixels, results and status against a frame-level model.
module tb_net_frame_sequencer;

  localparam int unsigned DW  = 16;
  localparam int unsigned PIX = 784;
  localparam int unsigned OW  = 4;
  localparam int unsigned TO  = 50;
  localparam int unsigned CW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          net_valid;
  logic [DW-1:0] net_data;
  logic          net_out_valid = 1'b0;
  logic [OW-1:0] net_out_data = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [OW-1:0] res_digit;
  logic          res_err;
  logic          busy;
  logic [CW-1:0] frame_count;

  always #5 clk = ~clk;

  net_frame_sequencer #(
    .dataWidth(DW), .pixels(PIX), .outWidth(OW), .timeoutCycles(TO), .cntWidth(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .net_valid(net_valid), .net_data(net_data),
    .net_out_valid(net_out_valid), .net_out_data(net_out_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_digit(res_digit), .res_err(res_err),
    .busy(busy), .frame_count(frame_count)
  );

  typedef struct packed {
    logic [OW-1:0] d;
    logic          e;
  } res_t;

  logic [DW-1:0] exp_pix[$];
  res_t          exp_res[$];
  int total = 0;
  int bad   = 0;

  // Frame-level model state, owned by the driver.
  bit mon_en      = 1'b0;
  bit model_ready = 1'b0;
  bit model_busy  = 1'b0;
  bit model_rv    = 1'b0;
  bit model_nv    = 1'b0;
  int model_fc    = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=unexpected expected=none t=%0t", name, $time);
  endfunction

  function automatic res_t mk_res(input logic [OW-1:0] d, input logic e);
    res_t r;
    r.d = d;
    r.e = e;
    return r;
  endfunction

  // Monitor: samples reset at the edge, compares everything on the falling edge.
  logic [DW-1:0] last_data = '0;
  bit            prev_rv   = 1'b0;
  bit            rst_seen  = 1'b0;
  logic [OW-1:0] held_d    = '0;
  logic          held_e    = 1'b0;
  res_t          got;
  logic [DW-1:0] pexp;

  always begin
    @(posedge clk);
    rst_seen = !rst_n;
    @(negedge clk);
    if (rst_seen) begin
      last_data = '0;
      prev_rv   = 1'b0;
    end
    if (mon_en) begin
      chk("s_ready", 32'(s_ready), 32'(model_ready));
      chk("busy", 32'(busy), 32'(model_busy));
      chk("frame_count", 32'(frame_count), 32'(model_fc & 32'hFFFF));
      chk("net_valid", 32'(net_valid), 32'(model_nv));
      if (net_valid) begin
        if (exp_pix.size() == 0) fail_now("net_extra_pixel");
        else begin
          pexp = exp_pix.pop_front();
          chk("net_data", 32'(net_data), 32'(pexp));
        end
        last_data = net_data;
      end else begin
        chk("net_data_hold", 32'(net_data), 32'(last_data));
      end
      chk("res_valid", 32'(res_valid), 32'(model_rv));
      if (res_valid && !prev_rv) begin
        if (exp_res.size() == 0) fail_now("res_extra");
        else begin
          got = exp_res.pop_front();
          chk("res_digit", 32'(res_digit), 32'(got.d));
          chk("res_err", 32'(res_err), 32'(got.e));
        end
        held_d = res_digit;
        held_e = res_err;
      end else if (res_valid) begin
        chk("res_digit_stable", 32'(res_digit), 32'(held_d));
        chk("res_err_stable", 32'(res_err), 32'(held_e));
      end
      prev_rv = res_valid;
    end
  end

  task automatic tick(input bit acc);
    @(posedge clk);
    #1;
    model_nv = acc;
  endtask

  task automatic chk_reset_outputs();
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_net_valid", 32'(net_valid), 32'd0);
    chk("rst_net_data", 32'(net_data), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_digit", 32'(res_digit), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    #1;
    rst_n       = 1'b1;
    model_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    model_ready = 1'b0;
    tick(0);
    s_valid    = 1'b0;
    s_last     = 1'b0;
    model_busy = 1'b0;
    model_rv   = 1'b0;
    model_fc   = 0;
    chk_reset_outputs();
  endtask

  // mode 0: ramp, continuous; 1: alternating gaps; 2: random gaps with stray results
  task automatic send_frame(input int mode, input int last_pos, input int rst_at);
    for (int i = 0; i < int'(PIX); i++) begin
      if (mode == 1 && i > 0) begin
        s_valid = 1'b0;
        s_data  = DW'($urandom);
        tick(0);
      end else if (mode == 2 && $urandom_range(2) == 0) begin
        repeat ($urandom_range(3, 1)) begin
          s_valid       = 1'b0;
          s_data        = DW'($urandom);
          net_out_valid = 1'($urandom_range(1));
          net_out_data  = OW'($urandom);
          tick(0);
        end
      end
      net_out_valid = 1'b0;
      s_valid = 1'b1;
      s_data  = (mode == 0) ? DW'(i) : DW'($urandom);
      s_last  = (i == last_pos);
      if (i == rst_at) begin
        do_reset();
        return;
      end
      exp_pix.push_back(s_data);
      tick(1);
      if (i == 0) model_busy = 1'b1;
      if (i == int'(PIX) - 1) model_ready = 1'b0;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // d < 0 lets the frame time out; otherwise the network answers d cycles into WAIT.
  task automatic finish_frame(input int d, input logic [OW-1:0] dig, input bit err,
                              input int hold, input bit stray);
    if (d < 0) begin
      repeat (TO - 1) tick(0);
      exp_res.push_back(mk_res('1, 1'b1));
      tick(0);
    end else begin
      repeat (d) tick(0);
      net_out_valid = 1'b1;
      net_out_data  = dig;
      exp_res.push_back(mk_res(dig, err));
      tick(0);
      net_out_valid = 1'b0;
    end
    model_rv = 1'b1;
    repeat (hold) begin
      if (stray) begin
        net_out_valid = 1'b1;
        net_out_data  = OW'(5);
        s_valid       = 1'b1;
        s_data        = DW'($urandom);
        s_last        = 1'($urandom_range(1));
      end
      tick(0);
    end
    net_out_valid = 1'b0;
    s_valid       = 1'b0;
    s_last        = 1'b0;
    res_ready     = 1'b1;
    tick(0);
    res_ready   = 1'b0;
    model_rv    = 1'b0;
    model_busy  = 1'b0;
    model_fc++;
    model_ready = 1'b1;
    chk("pix_drain", 32'(exp_pix.size()), 32'd0);
    chk("res_drain", 32'(exp_res.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    mon_en = 1'b1;

    send_frame(0, int'(PIX) - 1, -1);  finish_frame(20, 4'd7, 1'b0, 0, 1'b0);
    send_frame(1, int'(PIX) - 1, -1);  finish_frame(5, 4'd2, 1'b0, 3, 1'b0);
    send_frame(2, 100, -1);            finish_frame(10, 4'd3, 1'b1, 1, 1'b0);
    send_frame(2, int'(PIX) - 1, -1);  finish_frame(7, 4'd8, 1'b0, 0, 1'b0);
    send_frame(0, int'(PIX) - 1, -1);  finish_frame(-1, 4'd0, 1'b1, 2, 1'b0);
    send_frame(2, int'(PIX) - 1, -1);  finish_frame(TO - 1, 4'd9, 1'b0, 10, 1'b1);
    send_frame(0, -1, -1);             finish_frame(0, 4'd1, 1'b1, 0, 1'b0);
    send_frame(0, int'(PIX) - 1, 400);
    send_frame(0, int'(PIX) - 1, -1);  finish_frame(20, 4'd6, 1'b0, 2, 1'b0);
    chk("final_frame_count", 32'(frame_count), 32'd1);

    repeat (3) tick(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
